// File: rtl/spi_pkg.sv
// Shared definitions for the spi_master / spi_slave pair: state encoding,
// default word width and the smallest SCK half-period the slave can follow.
package spi_pkg;

  localparam int SPI_WIDTH       = 16;
  localparam int SPI_MIN_CLK_DIV = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_TRAIL = 3'd4,
    ST_GAP   = 3'd5
  } spi_state_e;

  // Counter width able to hold 0 .. max_count-1.
  function automatic int spi_cnt_w(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/spi_sync2.sv
// Two-flop synchroniser for a single asynchronous level (spi_miso here,
// spi_clk/spi_mosi/spi_str on the slave side).
module spi_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_master.sv
// 16-bit MSB-first SPI master with clk-divided SCK, framed by spi_str,
// capturing the slave's reply on spi_miso through a 2-flop synchroniser.
//
// state | meaning
// IDLE  | str high, waiting for start; d_tx loaded and first bit driven on start
// LEAD  | str low, SCK low for CLK_DIV cycles; first miso sample at the end
// HIGH  | SCK high; slave captures mosi; mosi advances when it ends
// LOW   | SCK low; miso sampled at the end, just before the next rising edge
// TRAIL | SCK low, str still low so the slave sees the final falling edge
// GAP   | str high for GAP cycles; d_rx/done presented in the first cycle
module spi_master
  import spi_pkg::*;
#(
  parameter int WIDTH   = SPI_WIDTH,
  parameter int CLK_DIV = 8,
  parameter int GAP     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] d_tx,
  output logic [WIDTH-1:0] d_rx,
  output logic             busy,
  output logic             done,
  output logic             spi_clk,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic             spi_str
);

  localparam int HC_MAX = (CLK_DIV > GAP) ? CLK_DIV : GAP;
  localparam int HC_W   = spi_cnt_w(HC_MAX);
  localparam int BC_W   = spi_cnt_w(WIDTH);

  spi_state_e       state_q, state_d;
  logic [HC_W-1:0]  hc_q, hc_d;
  logic [BC_W-1:0]  bc_q, bc_d;
  logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0] d_rx_q, d_rx_d;
  logic             mosi_q, mosi_d;
  logic             sclk_q, sclk_d;
  logic             str_q, str_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic miso_s;
  logic half_last;
  logic gap_last;
  logic bit_last;

  spi_sync2 u_sync_miso (
    .clk   (clk),
    .reset (reset),
    .d_i   (spi_miso),
    .q_o   (miso_s)
  );

  assign half_last = (hc_q == HC_W'(CLK_DIV - 1));
  assign gap_last  = (hc_q == HC_W'(GAP - 1));
  assign bit_last  = (bc_q == BC_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hc_q    <= '0;
      bc_q    <= '0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      d_rx_q  <= '0;
      mosi_q  <= 1'b1;
      sclk_q  <= 1'b0;
      str_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      bc_q    <= bc_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      d_rx_q  <= d_rx_d;
      mosi_q  <= mosi_d;
      sclk_q  <= sclk_d;
      str_q   <= str_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    bc_d    = bc_q;
    tx_sh_d = tx_sh_q;
    rx_sh_d = rx_sh_q;
    d_rx_d  = d_rx_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          tx_sh_d = d_tx;
          mosi_d  = d_tx[WIDTH-1];
          bc_d    = '0;
          hc_d    = '0;
          state_d = ST_LEAD;
        end
      end
      ST_LEAD, ST_LOW: begin
        if (half_last) begin
          rx_sh_d = {rx_sh_q[WIDTH-2:0], miso_s};
          hc_d    = '0;
          state_d = ST_HIGH;
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (half_last) begin
          hc_d = '0;
          if (bit_last) begin
            state_d = ST_TRAIL;
          end else begin
            // mosi only moves here, i.e. on the falling SCK edge
            tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
            mosi_d  = tx_sh_q[WIDTH-2];
            bc_d    = bc_q + 1'b1;
            state_d = ST_LOW;
          end
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      ST_TRAIL: begin
        if (half_last) begin
          // registered on entry to GAP so done and d_rx line up in its first cycle
          d_rx_d  = rx_sh_q;
          done_d  = 1'b1;
          hc_d    = '0;
          state_d = ST_GAP;
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_last) begin
          hc_d    = '0;
          state_d = ST_IDLE;
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      default: begin
        hc_d    = '0;
        state_d = ST_IDLE;
      end
    endcase

    sclk_d = (state_d == ST_HIGH);
    str_d  = !((state_d == ST_LEAD) || (state_d == ST_HIGH) ||
               (state_d == ST_LOW)  || (state_d == ST_TRAIL));
    busy_d = (state_d != ST_IDLE);
  end

  assign d_rx     = d_rx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_str  = str_q;

  a_done_pulse: assert property (@(posedge clk) disable iff (reset) done_q |=> !done_q);
  a_sclk_framed: assert property (@(posedge clk) disable iff (reset) str_q |-> !sclk_q);

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: loopback and a behavioural slave on a
// CLK_DIV=8 instance, plus a CLK_DIV=4 instance for the minimum half-period.
module tb_spi_master;
  import spi_pkg::*;

  localparam int W       = SPI_WIDTH;
  localparam int DIV_A   = 8;
  localparam int DIV_B   = SPI_MIN_CLK_DIV;
  localparam int GAP_CYC = 4;
  localparam int LAT_A   = (2 * W + 1) * DIV_A + 1;
  localparam int LAT_B   = (2 * W + 1) * DIV_B + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         a_start = 1'b0;
  logic [W-1:0] a_dtx   = '0;
  logic [W-1:0] a_drx;
  logic         a_busy, a_done, a_sclk, a_mosi, a_miso, a_str;
  logic         a_loop  = 1'b1;

  logic         b_start = 1'b0;
  logic [W-1:0] b_dtx   = '0;
  logic [W-1:0] b_drx;
  logic         b_busy, b_done, b_sclk, b_mosi, b_miso, b_str;

  spi_master #(.WIDTH(W), .CLK_DIV(DIV_A), .GAP(GAP_CYC)) u_a (
    .clk(clk), .reset(reset), .start(a_start), .d_tx(a_dtx), .d_rx(a_drx),
    .busy(a_busy), .done(a_done), .spi_clk(a_sclk), .spi_mosi(a_mosi),
    .spi_miso(a_miso), .spi_str(a_str)
  );

  spi_master #(.WIDTH(W), .CLK_DIV(DIV_B), .GAP(GAP_CYC)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .d_tx(b_dtx), .d_rx(b_drx),
    .busy(b_busy), .done(b_done), .spi_clk(b_sclk), .spi_mosi(b_mosi),
    .spi_miso(b_miso), .spi_str(b_str)
  );

  // Behavioural slaves: present MSB on str fall, advance on SCK fall, capture on SCK rise.
  logic [W-1:0] a_stx = '0, a_srx = '0, a_ssh = '0;
  logic         a_sarm = 1'b0, a_smiso = 1'b0;
  always @(a_str or negedge a_sclk) begin
    if (a_str) a_sarm = 1'b0;
    else begin
      if (!a_sarm) begin a_ssh = a_stx; a_sarm = 1'b1; end
      else a_ssh = {a_ssh[W-2:0], 1'b0};
      a_smiso = a_ssh[W-1];
    end
  end
  always @(posedge a_sclk) a_srx = {a_srx[W-2:0], a_mosi};
  assign a_miso = a_loop ? a_mosi : a_smiso;

  logic [W-1:0] b_stx = '0, b_srx = '0, b_ssh = '0;
  logic         b_sarm = 1'b0, b_smiso = 1'b0;
  always @(b_str or negedge b_sclk) begin
    if (b_str) b_sarm = 1'b0;
    else begin
      if (!b_sarm) begin b_ssh = b_stx; b_sarm = 1'b1; end
      else b_ssh = {b_ssh[W-2:0], 1'b0};
      b_smiso = b_ssh[W-1];
    end
  end
  always @(posedge b_sclk) b_srx = {b_srx[W-2:0], b_mosi};
  assign b_miso = b_smiso;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] a_exp[$];
  logic [W-1:0] b_exp[$];

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks += 8;
    if (a_str !== 1'b1)  begin n_fail++; $display("FAIL reset_str got %b want 1", a_str); end
    if (a_sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk got %b want 0", a_sclk); end
    if (a_mosi !== 1'b1) begin n_fail++; $display("FAIL reset_mosi got %b want 1", a_mosi); end
    if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", a_busy); end
    if (a_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", a_done); end
    if (a_drx !== '0)    begin n_fail++; $display("FAIL reset_drx got %h want 0000", a_drx); end
    if (b_str !== 1'b1)  begin n_fail++; $display("FAIL reset_b_str got %b want 1", b_str); end
    if (b_busy !== 1'b0) begin n_fail++; $display("FAIL reset_b_busy got %b want 0", b_busy); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_loopback();
    int lat = 0, rises = 0, dones = 0;
    logic prev_sclk = 1'b0;
    logic [W-1:0] exp;
    a_loop = 1'b1;
    a_dtx = 16'hA5C3;
    a_exp.push_back(16'hA5C3);
    a_start = 1'b1;
    for (int n = 1; n <= 320; n++) begin
      @(negedge clk);
      if (n == 1) begin
        a_start = 1'b0;
        a_dtx = 16'h0000;
        n_checks++;
        if (a_busy !== 1'b1) begin n_fail++; $display("FAIL loop_busy_rise got %b want 1", a_busy); end
      end
      if (a_sclk && !prev_sclk) rises++;
      prev_sclk = a_sclk;
      if (a_done === 1'b1) begin
        dones++;
        if (lat == 0 && a_exp.size() > 0) begin
          lat = n;
          exp = a_exp.pop_front();
          n_checks++;
          if (a_drx !== exp) begin n_fail++; $display("FAIL loop_drx got %h want %h", a_drx, exp); end
        end
      end
    end
    n_checks += 4;
    if (lat != LAT_A) begin n_fail++; $display("FAIL loop_latency got %0d want %0d", lat, LAT_A); end
    if (rises != W)   begin n_fail++; $display("FAIL loop_sck_rises got %0d want %0d", rises, W); end
    if (dones != 1)   begin n_fail++; $display("FAIL loop_done_count got %0d want 1", dones); end
    if (a_busy !== 1'b0 || a_str !== 1'b1) begin
      n_fail++; $display("FAIL loop_idle_after got busy=%b str=%b want busy=0 str=1", a_busy, a_str);
    end
  endtask

  task automatic test_slave();
    bit seen = 0;
    logic [W-1:0] exp;
    a_loop = 1'b0;
    a_stx = 16'hBEEF;
    a_dtx = 16'h1234;
    a_exp.push_back(16'hBEEF);
    a_start = 1'b1;
    for (int n = 1; n <= 320 && !seen; n++) begin
      @(negedge clk);
      if (n == 1) a_start = 1'b0;
      if (a_done === 1'b1 && a_exp.size() > 0) begin
        seen = 1;
        exp = a_exp.pop_front();
        n_checks++;
        if (a_drx !== exp) begin n_fail++; $display("FAIL slave_master_drx got %h want %h", a_drx, exp); end
      end
    end
    n_checks += 2;
    if (!seen) begin n_fail++; $display("FAIL slave_done_timeout got none want done"); end
    if (a_srx !== 16'h1234) begin n_fail++; $display("FAIL slave_rx got %h want 1234", a_srx); end
    repeat (GAP_CYC + 2) @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int dones = 0, busy_low = 0;
    logic [W-1:0] exp;
    a_loop = 1'b1;
    a_dtx = 16'h3C3C;
    a_exp.push_back(16'h3C3C);
    a_start = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == 1)  a_start = 1'b0;
      if (n == 50) begin a_start = 1'b1; a_dtx = 16'hFFFF; end
      if (n == 51) a_start = 1'b0;
      if (dones == 0 && a_busy !== 1'b1) busy_low++;
      if (a_done === 1'b1) begin
        dones++;
        if (a_exp.size() > 0) begin
          exp = a_exp.pop_front();
          n_checks++;
          if (a_drx !== exp) begin n_fail++; $display("FAIL busy_drx got %h want %h", a_drx, exp); end
        end
      end
    end
    n_checks += 2;
    if (dones != 1)    begin n_fail++; $display("FAIL busy_done_count got %0d want 1", dones); end
    if (busy_low != 0) begin n_fail++; $display("FAIL busy_dropped got %0d low cycles want 0", busy_low); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [3];
    int dones = 0, rises = 0, gaps = 0, str_run = 0;
    logic prev_busy = 1'b0, prev_str = 1'b1;
    logic [W-1:0] exp;
    words[0] = 16'h0001; words[1] = 16'h8000; words[2] = 16'hFFFF;
    a_loop = 1'b1;
    a_dtx = words[0];
    a_exp.push_back(words[0]);
    a_start = 1'b1;
    for (int n = 1; n <= 1000; n++) begin
      @(negedge clk);
      if (a_busy && !prev_busy) begin
        rises++;
        if (rises < 3) begin a_dtx = words[rises]; a_exp.push_back(words[rises]); end
        else a_start = 1'b0;
      end
      prev_busy = a_busy;
      if (a_str) str_run++;
      if (!a_str && prev_str && dones > 0) begin
        gaps++;
        n_checks++;
        if (str_run != GAP_CYC + 1) begin
          n_fail++; $display("FAIL b2b_gap got %0d str-high cycles want %0d", str_run, GAP_CYC + 1);
        end
      end
      if (!a_str) str_run = 0;
      prev_str = a_str;
      if (a_done === 1'b1) begin
        dones++;
        if (a_exp.size() > 0) begin
          exp = a_exp.pop_front();
          n_checks++;
          if (a_drx !== exp) begin n_fail++; $display("FAIL b2b_drx got %h want %h", a_drx, exp); end
        end
      end
    end
    n_checks += 2;
    if (dones != 3) begin n_fail++; $display("FAIL b2b_done_count got %0d want 3", dones); end
    if (gaps != 2)  begin n_fail++; $display("FAIL b2b_gap_count got %0d want 2", gaps); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    bit seen = 0;
    logic [W-1:0] exp;
    a_loop = 1'b1;
    a_dtx = 16'h1234;
    a_exp.push_back(16'h1234);
    a_start = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 1) a_start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks += 4;
    if (a_str !== 1'b1)  begin n_fail++; $display("FAIL rst_mid_str got %b want 1", a_str); end
    if (a_sclk !== 1'b0) begin n_fail++; $display("FAIL rst_mid_sclk got %b want 0", a_sclk); end
    if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", a_busy); end
    if (a_drx !== '0)    begin n_fail++; $display("FAIL rst_mid_drx got %h want 0000", a_drx); end
    reset = 1'b0;
    a_exp.delete();
    for (int n = 0; n < 320; n++) begin
      @(negedge clk);
      if (a_done === 1'b1) dones++;
    end
    n_checks += 2;
    if (dones != 0) begin n_fail++; $display("FAIL rst_mid_done got %0d pulses want 0", dones); end
    if (a_drx !== '0) begin n_fail++; $display("FAIL rst_mid_drx_hold got %h want 0000", a_drx); end
    a_dtx = 16'h5A5A;
    a_exp.push_back(16'h5A5A);
    a_start = 1'b1;
    for (int n = 1; n <= 320 && !seen; n++) begin
      @(negedge clk);
      if (n == 1) a_start = 1'b0;
      if (a_done === 1'b1 && a_exp.size() > 0) begin
        seen = 1;
        exp = a_exp.pop_front();
        n_checks++;
        if (a_drx !== exp) begin n_fail++; $display("FAIL rst_fresh_drx got %h want %h", a_drx, exp); end
      end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rst_fresh_timeout got none want done"); end
    repeat (GAP_CYC + 2) @(negedge clk);
  endtask

  task automatic test_min_div();
    logic [W-1:0] mtx [2];
    logic [W-1:0] stx [2];
    logic [W-1:0] exp;
    mtx[0] = 16'hFFFF; stx[0] = 16'h0000;
    mtx[1] = 16'h0000; stx[1] = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      int lat = 0;
      b_dtx = mtx[k];
      b_stx = stx[k];
      b_exp.push_back(stx[k]);
      b_start = 1'b1;
      for (int n = 1; n <= 200 && lat == 0; n++) begin
        @(negedge clk);
        if (n == 1) b_start = 1'b0;
        if (b_done === 1'b1 && b_exp.size() > 0) begin
          lat = n;
          exp = b_exp.pop_front();
          n_checks++;
          if (b_drx !== exp) begin n_fail++; $display("FAIL div4_master_drx[%0d] got %h want %h", k, b_drx, exp); end
        end
      end
      n_checks += 2;
      if (lat != LAT_B) begin n_fail++; $display("FAIL div4_latency[%0d] got %0d want %0d", k, lat, LAT_B); end
      if (b_srx !== mtx[k]) begin n_fail++; $display("FAIL div4_slave_rx[%0d] got %h want %h", k, b_srx, mtx[k]); end
      repeat (GAP_CYC + 2) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_slave();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_min_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- 16-bit SPI master that generates spi_clk, spi_mosi and spi_str for the spi_slave block and captures its spi_miso reply.
- Sits directly upstream of spi_slave, on the host/FPGA side of the link.
- The slave oversamples the link with its own clk, so this block drives slow, clean edges (a clk-divided SCK) and frames each word with spi_str.

Parameters:
WIDTH, 16, bits per transfer; MSB first
CLK_DIV, 8, clk cycles per SCK half-period; legal values are 4 or more, so the slave's two-stage synchroniser sees every level
GAP, 4, clk cycles spi_str is held high after a word before the next start is accepted; legal values are 2 or more

Ports:
clk       input   1      system clock, all logic on posedge
reset     input   1      synchronous, active-high
start     input   1      request a transfer; sampled only in IDLE
d_tx      input   WIDTH  word to send; captured on the accepted start
d_rx      output  WIDTH  last word received from spi_miso
busy      output  1      high from the cycle after an accepted start until return to IDLE
done      output  1      one-cycle pulse; d_rx is valid from this cycle
spi_clk   output  1      SCK; idles low
spi_mosi  output  1      serial data to the slave
spi_miso  input   1      serial data from the slave, asynchronous to clk
spi_str   output  1      frame strobe; high when idle, low during a word

Behaviour:
- Reset values: spi_clk=0, spi_mosi=1, spi_str=1, busy=0, done=0, d_rx=0, state=IDLE, all counters 0.
- Reset is synchronous and active-high. It aborts any transfer immediately.
- spi_miso passes through a 2-flop synchroniser. The value used for sampling is the synchroniser output.
- A half-period counter hc runs from 0 to CLK_DIV-1. A bit counter bc runs from 0 to WIDTH-1. A shift register tx_sh holds outgoing data and rx_sh holds incoming data.
- State IDLE:
  - Outputs: str=1, sclk=0, busy=0.
  - If start=1: load tx_sh=d_tx, drive mosi=d_tx[WIDTH-1], set bc=0 and hc=0, go to LEAD.
- State LEAD (CLK_DIV cycles):
  - Outputs: str=0, sclk=0.
  - On hc=CLK_DIV-1: shift the synchronised miso into rx_sh LSB, then go to HIGH.
- State HIGH (CLK_DIV cycles):
  - Output: sclk=1. The slave captures mosi on the rising edge.
  - On hc=CLK_DIV-1:
    - if bc=WIDTH-1, go to TRAIL;
    - otherwise shift tx_sh left, drive mosi with the new MSB, increment bc, go to LOW.
  - mosi changes only at a falling SCK edge.
- State LOW (CLK_DIV cycles):
  - Output: sclk=0.
  - On hc=CLK_DIV-1: shift miso into rx_sh, then go to HIGH.
- State TRAIL (CLK_DIV cycles):
  - Outputs: sclk=0, str=0.
  - Gives the slave time to register the last falling edge.
  - On the last cycle go to GAP.
- State GAP (GAP cycles):
  - Output: str=1.
  - In the first GAP cycle: d_rx<=rx_sh and done=1 for exactly one cycle.
  - When the GAP count expires, return to IDLE.
- A transfer is exactly (2*WIDTH+1)*CLK_DIV clk cycles from the first LEAD cycle to the last TRAIL cycle. For the defaults that is 264 cycles.
- Exactly WIDTH rising SCK edges and WIDTH miso samples occur per transfer.
- Bit ordering:
  - The first miso sample (end of LEAD) becomes d_rx[WIDTH-1].
  - The last sample (end of the final LOW) becomes d_rx[0].
- Boundary conditions:
  - start while busy is ignored; no queueing.
  - start held high continuously produces back-to-back words separated by GAP+1 cycles of str high.
  - Changes on d_tx after the accepted start do not affect the word in flight.
  - Reset mid-word: str returns high on the next cycle and sclk goes low. No done pulse is generated, and d_rx keeps its reset value of 0.

Decomposition:
- Shared package spi_pkg holds:
  - state encoding localparams (IDLE, LEAD, HIGH, LOW, TRAIL, GAP);
  - WIDTH default (16) and the minimum CLK_DIV (4), shared with spi_slave.
- One natural sub-module, spi_sync2: a 2-flop synchroniser instantiated for spi_miso, reusable by the slave.

Test Plan:
- Loopback with spi_miso tied to spi_mosi, d_tx=16'hA5C3, start pulse:
  - d_rx=16'hA5C3 at done;
  - exactly 16 SCK rising edges;
  - done exactly (33*CLK_DIV)+1 cycles after start.
- Connected to spi_slave with d_tx(master)=16'h1234 and slave d_tx=16'hBEEF:
  - slave d_rx=16'h1234 after its ready pulse;
  - master d_rx=16'hBEEF.
- start asserted again at cycle 50 of a transfer: ignored. A single done pulse, and busy stays high continuously until IDLE.
- start held high for three words with d_tx=16'h0001, 16'h8000, 16'hFFFF:
  - three done pulses;
  - str high for GAP+1 cycles between words;
  - loopback d_rx matches each word.
- reset asserted at cycle 100 of a transfer:
  - next cycle str=1, sclk=0, busy=0;
  - no done pulse;
  - a fresh start with d_tx=16'h5A5A completes correctly.
- CLK_DIV=4 with spi_slave: 16'hFFFF and 16'h0000 received intact in both directions. Checks the minimum legal half-period.
